alu_core: RTL and testbench

- Registered 8-bit ALU for the Hephaestus datapath.
- Each clock it latches one operation on operands A and B, selected by a 4-bit function code.
- Outputs: an 8-bit result, the high byte of multiply products, and a 4-bit status register (SREG).
- Sits between the register file (operand source) and writeback/branch logic (SREG consumer).

---
 rtl/alu_core.sv | 177 +++++++++++++++++
 tb/tb_alu_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered ALU: one operation per clock on A/B chosen by a 4-bit opcode,
// producing a result, the high half of multiply products and a C/Z/N/V status register.
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       function_select_lines,
  output logic [WIDTH-1:0] reg_out,
  output logic [WIDTH-1:0] mul_high,
  output logic [3:0]       SREG
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_INC  = 4'd13;
  localparam logic [3:0] OP_MULS = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;

  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] mul_high_reg, mul_high_next;
  logic [3:0]       sreg_reg, sreg_next;

  logic [WIDTH:0]          add_ext, sub_ext;
  logic [2*WIDTH-1:0]      prod_u;
  logic signed [2*WIDTH-1:0] prod_s;
  logic                    c_old;

  logic [WIDTH-1:0] r;
  logic c_f, z_f, n_f, v_f;
  logic write_result, write_flags, flags_from_r, shift_v;

  assign c_old   = sreg_reg[0];
  assign add_ext = {1'b0, A} + {1'b0, B};
  // Top bit of the widened difference is the unsigned borrow.
  assign sub_ext = {1'b0, A} - {1'b0, B};
  assign prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign prod_s  = $signed({{WIDTH{A[MSB]}}, A}) * $signed({{WIDTH{B[MSB]}}, B});

  always_comb begin
    result_next   = result_reg;
    mul_high_next = '0;
    sreg_next     = sreg_reg;
    r             = '0;
    c_f           = c_old;
    z_f           = 1'b0;
    n_f           = 1'b0;
    v_f           = 1'b0;
    write_result  = 1'b1;
    write_flags   = 1'b1;
    flags_from_r  = 1'b1;
    shift_v       = 1'b0;

    case (function_select_lines)
      OP_NOP: begin
        write_result  = 1'b0;
        write_flags   = 1'b0;
        mul_high_next = mul_high_reg;
      end
      OP_ADD: begin
        r   = add_ext[MSB:0];
        c_f = add_ext[WIDTH];
        v_f = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ add_ext[MSB]);
      end
      OP_SUB, OP_CMP: begin
        r   = sub_ext[MSB:0];
        c_f = sub_ext[WIDTH];
        v_f = (A[MSB] ^ B[MSB]) & (A[MSB] ^ sub_ext[MSB]);
        if (function_select_lines == OP_CMP) begin
          write_result  = 1'b0;
          mul_high_next = mul_high_reg;
        end
      end
      OP_MUL: begin
        r             = prod_u[MSB:0];
        mul_high_next = prod_u[2*WIDTH-1:WIDTH];
        flags_from_r  = 1'b0;
        c_f           = |prod_u[2*WIDTH-1:WIDTH];
        z_f           = (prod_u == '0);
      end
      OP_AND: r = A & B;
      OP_OR:  r = A | B;
      OP_XOR: r = A ^ B;
      OP_NOT: begin
        r   = ~A;
        c_f = 1'b1;
      end
      OP_LSL: begin
        r       = {A[MSB-1:0], 1'b0};
        c_f     = A[MSB];
        shift_v = 1'b1;
      end
      OP_LSR: begin
        r       = {1'b0, A[MSB:1]};
        c_f     = A[0];
        shift_v = 1'b1;
      end
      OP_ASR: begin
        r       = {A[MSB], A[MSB:1]};
        c_f     = A[0];
        shift_v = 1'b1;
      end
      OP_ROL: begin
        r       = {A[MSB-1:0], c_old};
        c_f     = A[MSB];
        shift_v = 1'b1;
      end
      OP_ROR: begin
        r       = {c_old, A[MSB:1]};
        c_f     = A[0];
        shift_v = 1'b1;
      end
      OP_INC: begin
        r   = A + 1'b1;
        v_f = (A == SIGNED_MAX);
      end
      default: begin  // OP_MULS
        r             = prod_s[MSB:0];
        mul_high_next = prod_s[2*WIDTH-1:WIDTH];
        flags_from_r  = 1'b0;
        c_f           = 1'b0;
        z_f           = (prod_s == '0);
        n_f           = prod_s[2*WIDTH-1];
        // Representable only if the upper half plus result MSB are all sign copies.
        v_f           = ~((&prod_s[2*WIDTH-1:MSB]) | ~(|prod_s[2*WIDTH-1:MSB]));
      end
    endcase

    if (flags_from_r) begin
      z_f = (r == '0);
      n_f = r[MSB];
    end
    if (shift_v) begin
      v_f = n_f ^ c_f;
    end
    if (write_result) begin
      result_next = r;
    end
    if (write_flags) begin
      sreg_next = {v_f, n_f, z_f, c_f};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg   <= '0;
      mul_high_reg <= '0;
      sreg_reg     <= '0;
    end else begin
      result_reg   <= result_next;
      mul_high_reg <= mul_high_next;
      sreg_reg     <= sreg_next;
    end
  end

  assign reg_out  = result_reg;
  assign mul_high = mul_high_reg;
  assign SREG     = sreg_reg;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed literal checks from hand arithmetic plus randomized
// traffic compared every cycle against an integer-arithmetic reference model.
module tb_alu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a_in, b_in;
  logic [3:0] sel;
  logic [7:0] reg_out, mul_high;
  logic [3:0] sreg;

  alu_core #(.WIDTH(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .A                     (a_in),
    .B                     (b_in),
    .function_select_lines (sel),
    .reg_out               (reg_out),
    .mul_high              (mul_high),
    .SREG                  (sreg)
  );

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  logic [7:0] er = 8'h00;
  logic [7:0] eh = 8'h00;
  logic [3:0] es = 4'h0;

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference model: plain integer arithmetic on the architectural rules.
  task automatic model_step(input bit rst, input int a, input int b, input int op);
    int r, h, c, z, n, v, p, sa, sb, cold;
    bit flags_from_r;
    if (rst) begin
      er = 8'h00; eh = 8'h00; es = 4'h0;
      return;
    end
    if (op == 0) return;
    sa = to_signed8(a);
    sb = to_signed8(b);
    cold = int'(es[0]);
    r = int'(er); h = 0; c = cold; v = 0; z = 0; n = 0;
    flags_from_r = 1'b1;
    case (op)
      1: begin
        r = (a + b) % 256; c = (a + b > 255);
        v = (sa + sb > 127 || sa + sb < -128);
      end
      2, 15: begin
        r = (a - b + 256) % 256; c = (a < b);
        v = (sa - sb > 127 || sa - sb < -128);
      end
      3: begin
        p = a * b; r = p % 256; h = p / 256;
        c = (h != 0); z = (p == 0); n = 0; v = 0; flags_from_r = 1'b0;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: begin r = 255 - a; c = 1; end
      8: begin r = (a * 2) % 256; c = (a >= 128); end
      9: begin r = a / 2; c = a % 2; end
      10: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
      11: begin r = (a * 2) % 256 + cold; c = (a >= 128); end
      12: begin r = a / 2 + cold * 128; c = a % 2; end
      13: begin r = (a + 1) % 256; v = (a == 127); end
      default: begin
        p = sa * sb; r = (p + 65536) % 256; h = ((p + 65536) % 65536) / 256;
        c = 0; z = (p == 0); n = (p < 0); v = (p > 127 || p < -128);
        flags_from_r = 1'b0;
      end
    endcase
    if (flags_from_r) begin
      z = (r == 0);
      n = (r >= 128);
    end
    if (op >= 8 && op <= 12) v = n ^ c;
    es = {v[0], n[0], z[0], c[0]};
    if (op == 15) begin
      return;  // result and high byte held
    end
    er = 8'(r);
    eh = 8'(h);
  endtask

  always @(posedge clk) model_step(reset, int'(a_in), int'(b_in), int'(sel));

  always @(negedge clk) begin
    if (chk_en) begin
      compared++;
      if (reg_out !== er) begin
        mismatched++;
        $display("FAIL model_reg_out: got %02h expected %02h", reg_out, er);
      end
      compared++;
      if (mul_high !== eh) begin
        mismatched++;
        $display("FAIL model_mul_high: got %02h expected %02h", mul_high, eh);
      end
      compared++;
      if (sreg !== es) begin
        mismatched++;
        $display("FAIL model_sreg: got %04b expected %04b", sreg, es);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] s);
    reset = rst; a_in = a; b_in = b; sel = s;
    @(posedge clk);
    #1;
    $display("rst=%0b op=%0d A=%02h B=%02h -> reg_out=%02h mul_high=%02h SREG=%04b",
             rst, s, a, b, reg_out, mul_high, sreg);
  endtask

  initial begin
    reset = 1'b1; a_in = 8'h00; b_in = 8'h00; sel = 4'd0;
    @(negedge clk);
    step(1'b1, 8'h00, 8'h00, 4'd0);
    chk_en = 1'b1;
    chk("reset_reg_out", reg_out, 8'h00);
    chk("reset_mul_high", mul_high, 8'h00);
    chk("reset_sreg", {4'h0, sreg}, 8'h00);

    step(1'b0, 8'd200, 8'd77, 4'd3);
    step(1'b0, 8'd9, 8'd250, 4'd7);
    step(1'b1, 8'd6, 8'd9, 4'd1);
    chk("reset_over_add_reg", reg_out, 8'h00);
    chk("reset_over_add_mh", mul_high, 8'h00);
    chk("reset_over_add_sreg", {4'h0, sreg}, 8'h00);

    step(1'b0, 8'd6, 8'd9, 4'd1);
    chk("add_reg", reg_out, 8'd15);
    chk("add_sreg", {4'h0, sreg}, 8'h00);
    step(1'b0, 8'd3, 8'd6, 4'd2);
    chk("sub_reg", reg_out, 8'hFD);
    chk("sub_sreg", {4'h0, sreg}, 8'b0101);
    step(1'b0, 8'd77, 8'd11, 4'd0);
    chk("nop_reg", reg_out, 8'hFD);
    chk("nop_sreg", {4'h0, sreg}, 8'b0101);

    step(1'b0, 8'd127, 8'd125, 4'd3);
    chk("mul_high", mul_high, 8'h3E);
    chk("mul_reg", reg_out, 8'h03);
    chk("mul_sreg", {4'h0, sreg}, 8'b0001);
    step(1'b0, 8'd127, 8'hFD, 4'd14);
    chk("muls_high", mul_high, 8'hFE);
    chk("muls_reg", reg_out, 8'h83);
    chk("muls_sreg", {4'h0, sreg}, 8'b1100);
    step(1'b0, 8'd1, 8'd2, 4'd4);
    chk("and_clears_mh", mul_high, 8'h00);
    chk("and_reg", reg_out, 8'h00);
    chk("and_sreg", {4'h0, sreg}, 8'b0010);

    step(1'b0, 8'd13, 8'd85, 4'd6);
    chk("xor_reg", reg_out, 8'h58);
    step(1'b0, 8'd13, 8'd85, 4'd7);
    chk("not_reg", reg_out, 8'hF2);
    chk("not_c", {7'h0, sreg[0]}, 8'h01);

    step(1'b0, 8'd120, 8'd0, 4'd8);
    chk("lsl_reg", reg_out, 8'hF0);
    chk("lsl_sreg", {4'h0, sreg}, 8'b1100);
    step(1'b0, 8'd0, 8'd0, 4'd7);
    step(1'b0, 8'hFF, 8'd0, 4'd13);
    chk("inc_wrap_reg", reg_out, 8'h00);
    chk("inc_wrap_sreg", {4'h0, sreg}, 8'b0011);
    step(1'b0, 8'h7F, 8'd0, 4'd13);
    chk("inc_ovf_reg", reg_out, 8'h80);
    chk("inc_ovf_sreg", {4'h0, sreg}, 8'b1101);

    step(1'b0, 8'd5, 8'd5, 4'd15);
    chk("cmp_reg_held", reg_out, 8'h80);
    chk("cmp_sreg", {4'h0, sreg}, 8'b0010);
    step(1'b0, 8'd5, 8'd5, 4'd5);
    chk("or_reg", reg_out, 8'd5);
    step(1'b0, 8'd5, 8'd7, 4'(20));
    chk("sel20_as_and", reg_out, 8'd5);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 49) == 0), 8'($urandom), 8'($urandom), 4'($urandom));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
